// File: rtl/instr_register_exec.sv
// instr_register_exec
//   Design-side end of the instruction-register interface. Accepts instruction
//   writes (opcode + two signed operands), computes the 64-bit result, and
//   stores {opcode, operand_a, operand_b, result} in a DEPTH-entry register file.
//   ZERO/PASSA/PASSB/ADD/SUB/MULT complete on the accept edge. DIV/MOD with a
//   non-zero divisor run a 32-step restoring divider, and the write port stalls
//   via load_ready until the result is written back.
//
// Ports
//   clk              clock, all state updates on rising edge
//   reset            synchronous active-high reset
//   load_en          write request, accepted when load_en && load_ready
//   load_ready       write port can accept (low while a divide is in flight)
//   operand_a/b      signed operands
//   opcode           ZERO=0 PASSA=1 PASSB=2 ADD=3 SUB=4 MULT=5 DIV=6 MOD=7
//   write_pointer    destination entry
//   read_pointer     entry to read
//   instruction_word regfile[read_pointer], combinational
//   busy             high while a DIV/MOD is in flight
//   op_count         (INSTR_REG_STATS_EN only) saturating count of completed writes
//
// Optional feature macro: INSTR_REG_STATS_EN
module instr_register_exec #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned OPERAND_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  output logic                          load_ready,
  input  logic [OPERAND_W-1:0]          operand_a,
  input  logic [OPERAND_W-1:0]          operand_b,
  input  logic [2:0]                    opcode,
  input  logic [$clog2(DEPTH)-1:0]      write_pointer,
  input  logic [$clog2(DEPTH)-1:0]      read_pointer,
  output logic [3+4*OPERAND_W-1:0]      instruction_word,
  output logic                          busy
`ifdef INSTR_REG_STATS_EN
  ,
  output logic [15:0]                   op_count
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned RES_W  = 2 * OPERAND_W;
  localparam int unsigned WORD_W = 3 + 2 * OPERAND_W + RES_W;
  localparam int unsigned CNT_W  = $clog2(OPERAND_W);

  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;

  typedef enum logic [1:0] {IDLE, DIV_RUN, WRITEBACK} state_t;

  logic [WORD_W-1:0]       regfile [DEPTH];
  state_t                  state;
  logic [2:0]              cap_op;
  logic [AW-1:0]           cap_ptr;
  logic [OPERAND_W-1:0]    cap_a, cap_b;
  logic [OPERAND_W-1:0]    quo, rem, divisor;
  logic [CNT_W-1:0]        step;

  logic signed [RES_W-1:0] a_ext, b_ext;
  logic [RES_W-1:0]        single_res;
  logic                    div_start;
  logic [OPERAND_W-1:0]    abs_a, abs_b;
  logic [OPERAND_W:0]      rem_shift;
  logic                    ge;
  logic [OPERAND_W-1:0]    rem_next, quo_next;
  logic [RES_W-1:0]        q_mag, r_mag, wb_res;

  assign instruction_word = regfile[read_pointer];

  // Single-cycle result; DIV/MOD only land here when the divisor is zero (result 0)
  always_comb begin
    a_ext = RES_W'(signed'(operand_a));
    b_ext = RES_W'(signed'(operand_b));
    single_res = '0;
    case (opcode)
      OP_PASSA: single_res = a_ext;
      OP_PASSB: single_res = b_ext;
      OP_ADD:   single_res = a_ext + b_ext;
      OP_SUB:   single_res = a_ext - b_ext;
      OP_MULT:  single_res = a_ext * b_ext;
      default:  single_res = '0;
    endcase
  end

  // Divider operand magnitudes and one restoring step
  always_comb begin
    div_start = (opcode[2:1] == 2'b11) && (operand_b != '0);
    abs_a     = operand_a[OPERAND_W-1] ? (~operand_a) + OPERAND_W'(1) : operand_a;
    abs_b     = operand_b[OPERAND_W-1] ? (~operand_b) + OPERAND_W'(1) : operand_b;
    rem_shift = {rem, quo[OPERAND_W-1]};
    ge        = rem_shift >= {1'b0, divisor};
    rem_next  = ge ? rem_shift[OPERAND_W-1:0] - divisor : rem_shift[OPERAND_W-1:0];
    quo_next  = {quo[OPERAND_W-2:0], ge};
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend
  always_comb begin
    q_mag = RES_W'(quo);
    r_mag = RES_W'(rem);
    if (cap_op == OP_DIV)
      wb_res = (cap_a[OPERAND_W-1] ^ cap_b[OPERAND_W-1]) ? -q_mag : q_mag;
    else
      wb_res = cap_a[OPERAND_W-1] ? -r_mag : r_mag;
  end

  // Control FSM, divider datapath and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regfile[AW'(i)] <= '0;
      state      <= IDLE;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      cap_op     <= '0;
      cap_ptr    <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      quo        <= '0;
      rem        <= '0;
      divisor    <= '0;
      step       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            if (div_start) begin
              cap_op     <= opcode;
              cap_ptr    <= write_pointer;
              cap_a      <= operand_a;
              cap_b      <= operand_b;
              quo        <= abs_a;
              divisor    <= abs_b;
              rem        <= '0;
              step       <= '0;
              state      <= DIV_RUN;
              load_ready <= 1'b0;
              busy       <= 1'b1;
            end else begin
              regfile[write_pointer] <= {opcode, operand_a, operand_b, single_res};
            end
          end
        end
        DIV_RUN: begin
          quo  <= quo_next;
          rem  <= rem_next;
          step <= step + CNT_W'(1);
          if (step == CNT_W'(OPERAND_W - 1)) state <= WRITEBACK;
        end
        WRITEBACK: begin
          regfile[cap_ptr] <= {cap_op, cap_a, cap_b, wb_res};
          state            <= IDLE;
          load_ready       <= 1'b1;
          busy             <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_REG_STATS_EN
  logic write_done_c;

  assign write_done_c = ((state == IDLE) && load_en && !div_start) || (state == WRITEBACK);

  // Saturating count of completed register-file writes
  always_ff @(posedge clk) begin
    if (reset)
      op_count <= '0;
    else if (write_done_c && (op_count != 16'hFFFF))
      op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: doc/instr_register_exec.md
Name: instr_register_exec

Overview:
- Design-side end of the instruction-register interface: accepts instruction writes (opcode plus two operands) and computes the result.
- Stores the completed instruction_word in a DEPTH-entry register file.
- Returns any entry on a combinational read port.
- ZERO/PASSA/PASSB/ADD/SUB/MULT finish in one cycle. DIV/MOD use an iterative 32-step divider, so the write port has a ready handshake.

Parameters:
- DEPTH, 32, number of register-file entries; address_t is $clog2(DEPTH) bits (5).
- OPERAND_W, 32, operand width; operands are signed two's complement. Result width is 2*OPERAND_W (64).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- load_en  input  1  write request
- load_ready  output  1  write accepted on a rising edge when load_en && load_ready
- operand_a  input  OPERAND_W  signed operand A
- operand_b  input  OPERAND_W  signed operand B
- opcode  input  3  opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7
- write_pointer  input  5  destination entry
- read_pointer  input  5  entry to read
- instruction_word  output  3+2*OPERAND_W+64  {opc, op_a, op_b, result} of regfile[read_pointer]
- busy  output  1  high while a DIV/MOD is in flight

Behaviour:
- Reset, clk edge with reset=1:
  - every entry cleared to {ZERO,0,0,0}
  - FSM goes to IDLE; load_ready=1; busy=0
  - divider registers are cleared
  - reset has priority over any load_en in the same cycle
- Reset mid-DIV/MOD: the operation is aborted and no writeback occurs.
- FSM states: IDLE, DIV_RUN, WRITEBACK.
- IDLE, accept (load_en && load_ready):
  - non-DIV/MOD opcode: regfile[write_pointer] <= {opcode, a, b, result} on the same edge (write latency 1); stay in IDLE.
  - DIV/MOD with b==0: result=0, written the same edge; stay in IDLE.
  - DIV/MOD with b!=0: capture opcode, pointer, a and b; step counter <= 0; go to DIV_RUN.
- DIV_RUN:
  - one restoring-division step on |a|,|b| per cycle.
  - after 32 steps go to WRITEBACK.
  - load_ready=0 and busy=1 from the cycle after accept through WRITEBACK.
  - load_en is ignored while load_ready=0.
- WRITEBACK:
  - apply signs, write the captured entry, go to IDLE.
  - load_ready returns to 1 in the next cycle.
  - accept-to-write latency for DIV/MOD is 34 edges.
- Arithmetic rules:
  - operands are sign-extended to 64 bits before ADD, SUB and MULT.
  - MULT gives the full 64-bit signed product; no overflow is possible.
  - DIV truncates toward zero.
  - MOD sign follows the dividend, matching SV / and %.
  - Results are sign-extended to 64 bits.
  - -2^31 / -1 = +2^31 (fits in 64 bits).
- Read port:
  - instruction_word = regfile[read_pointer], combinational.
  - a same-edge write is visible after the edge; no same-cycle bypass.
  - during DIV_RUN the target entry keeps its old contents until WRITEBACK.
- Pointers are mod DEPTH: there is no range error, and 31 is a valid entry.
- A rewrite to an occupied entry overwrites it.

Optional Feature:
- Macro INSTR_REG_STATS_EN.
- Defined:
  - adds output op_count (16 bits), a saturating count of completed writebacks (single-cycle and divider).
  - stays at 16'hFFFF once reached.
  - cleared by reset.
  - a reset during DIV_RUN does not count the aborted operation.
- Undefined: no op_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then read all 32 entries -> every instruction_word = {ZERO,0,0,0}; load_ready=1; busy=0.
- Write ADD a=-7 b=5 to entry 3; read 3 on the next cycle -> opc=ADD, result=-2 (64'hFFFF_FFFF_FFFF_FFFE); load_ready stays 1.
- Write MULT a=-15 b=15 to 31, then SUB a=4 b=9 to 0 back-to-back -> entry 31 result=-225, entry 0 result=-5.
- Write DIV a=-15 b=4 to 7 -> load_ready=0 for 33 cycles; a load_en held high meanwhile is ignored; entry 7 holds the old value until edge 34, then result=-3. MOD with the same operands -> result=-3.
- Write DIV a=9 b=0 and MOD a=-9 b=0 -> single-cycle, result=0, busy never asserted.
- Start DIV a=100 b=3 to entry 5, assert reset at cycle 10 -> entry 5 = {ZERO,0,0,0}; FSM in IDLE; load_ready=1; with INSTR_REG_STATS_EN, op_count=0.
